// File: rtl/core_id_issue_pkg.sv
// core_id_issue_pkg
// Shared widths for the decode-to-execute issue stage and a small helper
// used by the forwarding select.
//
// Contents:
//   CORE_XLEN              integer register / operand width
//   CORE_PC_SIZE           program counter width
//   CORE_RFIDX_WIDTH       register file index width
//   CORE_IMM_WIDTH         decoded immediate width
//   CORE_DECINFO_BJ_WIDTH  branch/jump decoded instruction bus width
//   CORE_DECINFO_ALU_WIDTH ALU decoded instruction bus width
//   CORE_DECINFO_LSU_WIDTH load/store decoded instruction bus width
//   idx_match()            enable-qualified register index compare
//
// The optional performance counters are enabled by defining the macro
// CORE_ID_PERF_CNT_EN at build time; it is left undefined by default.
package core_id_issue_pkg;

  localparam int CORE_XLEN              = 32;
  localparam int CORE_PC_SIZE           = 32;
  localparam int CORE_RFIDX_WIDTH       = 5;
  localparam int CORE_IMM_WIDTH         = 32;
  localparam int CORE_DECINFO_BJ_WIDTH  = 10;
  localparam int CORE_DECINFO_ALU_WIDTH = 16;
  localparam int CORE_DECINFO_LSU_WIDTH = 12;

  // True when a producer with write-enable 'wen' targets register 'src_idx'.
  function automatic logic idx_match(input logic                        wen,
                                     input logic [CORE_RFIDX_WIDTH-1:0] dst_idx,
                                     input logic [CORE_RFIDX_WIDTH-1:0] src_idx);
    return wen & (dst_idx == src_idx);
  endfunction

endpackage

// File: rtl/core_id_fwd_sel.sv
// core_id_fwd_sel
// Combinational operand select for one source register of the issue stage.
// Picks, in priority order: zero (x0 or operand not read), the EX result,
// the WB result, then the register file read data. Flags a hazard when the
// EX result is needed but the EX stage has not produced it yet.
//
// Ports:
//   en        stage holds a valid instruction; when low the select idles
//   rs_ren    instruction reads this operand
//   rs_idx    source register index
//   rf_dat    register file read data for rs_idx
//   ex_wen    EX stage will write a register
//   ex_idx    EX destination index
//   ex_dat    EX result (only meaningful when exu_busy is low)
//   exu_busy  EX result not yet resolved (e.g. load in flight)
//   wb_en     WB stage writes a register this cycle
//   wb_idx    WB destination index
//   wb_dat    WB write data
//   op_dat    selected operand value
//   hazard    operand depends on an unresolved EX result
module core_id_fwd_sel
  import core_id_issue_pkg::*;
(
  input  logic                        en,
  input  logic                        rs_ren,
  input  logic [CORE_RFIDX_WIDTH-1:0] rs_idx,
  input  logic [CORE_XLEN-1:0]        rf_dat,
  input  logic                        ex_wen,
  input  logic [CORE_RFIDX_WIDTH-1:0] ex_idx,
  input  logic [CORE_XLEN-1:0]        ex_dat,
  input  logic                        exu_busy,
  input  logic                        wb_en,
  input  logic [CORE_RFIDX_WIDTH-1:0] wb_idx,
  input  logic [CORE_XLEN-1:0]        wb_dat,
  output logic [CORE_XLEN-1:0]        op_dat,
  output logic                        hazard
);

  // x0 reads as zero and is never forwarded, even when a producer claims
  // to write it, so the zero check sits ahead of both forwarding paths.
  // EX is younger than WB, so EX wins when both target the same register.
  always_comb begin
    op_dat = '0;
    hazard = 1'b0;
    if (en && rs_ren && (rs_idx != '0)) begin
      if (idx_match(ex_wen, ex_idx, rs_idx)) begin
        op_dat = ex_dat;
        hazard = exu_busy;
      end else if (idx_match(wb_en, wb_idx, rs_idx)) begin
        op_dat = wb_dat;
      end else begin
        op_dat = rf_dat;
      end
    end
  end

endmodule

// File: rtl/core_id_issue.sv
// core_id_issue
// Decode-to-execute issue stage. Holds one decoded instruction in a skid
// register, reads its sources from the register file (addressed from the
// held instruction), forwards from EX/WB, stalls on an unresolved EX result
// and drops the held instruction on a commit flush.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_in / ready_in         handshake with the decoder
//   i_*                         decoded instruction fields
//   rf_rs1_idx, rf_rs2_idx      register file read addresses
//   rf_rs1_dat, rf_rs2_dat      register file read data (combinational)
//   rd_*_ex_forward, exu_busy   EX forwarding and busy indication
//   wb_en, wb_idx, wb_data      writeback forwarding
//   cmt_pipeline_flush_req      flush from EX commit
//   valid_out / ready_out       handshake with the EX stage
//   o_*                         held instruction fields and resolved operands
//   perf_stall_cnt              (CORE_ID_PERF_CNT_EN) cycles stalled on hazard
//   perf_issue_cnt              (CORE_ID_PERF_CNT_EN) instructions issued
module core_id_issue
  import core_id_issue_pkg::*;
`ifdef CORE_ID_PERF_CNT_EN
#(
  parameter int PERF_CNT_WIDTH = 32
)
`endif
(
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic                              valid_in,
  output logic                              ready_in,
  input  logic [CORE_PC_SIZE-1:0]           i_pc,
  input  logic                              i_branch_predict,
  input  logic                              i_rs1_ren,
  input  logic                              i_rs2_ren,
  input  logic                              i_rd_wen,
  input  logic [CORE_RFIDX_WIDTH-1:0]       i_rs1_idx,
  input  logic [CORE_RFIDX_WIDTH-1:0]       i_rs2_idx,
  input  logic [CORE_RFIDX_WIDTH-1:0]       i_rd_idx,
  input  logic [CORE_IMM_WIDTH-1:0]         i_imm,
  input  logic [CORE_DECINFO_BJ_WIDTH-1:0]  i_bj_dec_inst_bus,
  input  logic [CORE_DECINFO_ALU_WIDTH-1:0] i_alu_inst_bus,
  input  logic [CORE_DECINFO_LSU_WIDTH-1:0] i_lsu_inst_bus,

  output logic [CORE_RFIDX_WIDTH-1:0]       rf_rs1_idx,
  output logic [CORE_RFIDX_WIDTH-1:0]       rf_rs2_idx,
  input  logic [CORE_XLEN-1:0]              rf_rs1_dat,
  input  logic [CORE_XLEN-1:0]              rf_rs2_dat,

  input  logic [CORE_RFIDX_WIDTH-1:0]       rd_idx_ex_forward,
  input  logic                              rd_wen_ex_forward,
  input  logic [CORE_XLEN-1:0]              rd_dat_ex_forward,
  input  logic                              exu_busy,

  input  logic                              wb_en,
  input  logic [CORE_RFIDX_WIDTH-1:0]       wb_idx,
  input  logic [CORE_XLEN-1:0]              wb_data,

  input  logic                              cmt_pipeline_flush_req,

  output logic                              valid_out,
  input  logic                              ready_out,
  output logic [CORE_PC_SIZE-1:0]           o_pc,
  output logic                              o_branch_predict,
  output logic                              o_rs1_ren,
  output logic                              o_rs2_ren,
  output logic                              o_rd_wen,
  output logic [CORE_RFIDX_WIDTH-1:0]       o_rs1_idx,
  output logic [CORE_RFIDX_WIDTH-1:0]       o_rs2_idx,
  output logic [CORE_RFIDX_WIDTH-1:0]       o_rd_idx,
  output logic [CORE_IMM_WIDTH-1:0]         o_imm,
  output logic [CORE_DECINFO_BJ_WIDTH-1:0]  o_bj_dec_inst_bus,
  output logic [CORE_DECINFO_ALU_WIDTH-1:0] o_alu_inst_bus,
  output logic [CORE_DECINFO_LSU_WIDTH-1:0] o_lsu_inst_bus,
`ifdef CORE_ID_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0]         perf_stall_cnt,
  output logic [PERF_CNT_WIDTH-1:0]         perf_issue_cnt,
`endif
  output logic [CORE_XLEN-1:0]              o_rs1_dat,
  output logic [CORE_XLEN-1:0]              o_rs2_dat
);

  logic                              full;
  logic                              full_next;

  logic [CORE_PC_SIZE-1:0]           p_pc;
  logic                              p_branch_predict;
  logic                              p_rs1_ren;
  logic                              p_rs2_ren;
  logic                              p_rd_wen;
  logic [CORE_RFIDX_WIDTH-1:0]       p_rs1_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       p_rs2_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       p_rd_idx;
  logic [CORE_IMM_WIDTH-1:0]         p_imm;
  logic [CORE_DECINFO_BJ_WIDTH-1:0]  p_bj_dec_inst_bus;
  logic [CORE_DECINFO_ALU_WIDTH-1:0] p_alu_inst_bus;
  logic [CORE_DECINFO_LSU_WIDTH-1:0] p_lsu_inst_bus;

  logic                              rs1_hazard;
  logic                              rs2_hazard;
  logic                              hazard;
  logic                              flush;
  logic                              issue;
  logic                              accept;

  assign flush = cmt_pipeline_flush_req;

  // Sources are read using the held instruction, so the register file
  // address stays stable across a stall and the read data tracks any
  // register file update that lands while we wait.
  assign rf_rs1_idx = p_rs1_idx;
  assign rf_rs2_idx = p_rs2_idx;

  core_id_fwd_sel u_fwd_rs1 (
    .en       (full),
    .rs_ren   (p_rs1_ren),
    .rs_idx   (p_rs1_idx),
    .rf_dat   (rf_rs1_dat),
    .ex_wen   (rd_wen_ex_forward),
    .ex_idx   (rd_idx_ex_forward),
    .ex_dat   (rd_dat_ex_forward),
    .exu_busy (exu_busy),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .wb_dat   (wb_data),
    .op_dat   (o_rs1_dat),
    .hazard   (rs1_hazard)
  );

  core_id_fwd_sel u_fwd_rs2 (
    .en       (full),
    .rs_ren   (p_rs2_ren),
    .rs_idx   (p_rs2_idx),
    .rf_dat   (rf_rs2_dat),
    .ex_wen   (rd_wen_ex_forward),
    .ex_idx   (rd_idx_ex_forward),
    .ex_dat   (rd_dat_ex_forward),
    .exu_busy (exu_busy),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .wb_dat   (wb_data),
    .op_dat   (o_rs2_dat),
    .hazard   (rs2_hazard)
  );

  // A flush kills the held instruction in the same cycle it is raised, so
  // it masks valid_out directly rather than waiting for full to clear.
  // ready_in is held high during a flush: whatever the decoder presents in
  // that cycle is taken off its hands and thrown away, since it belongs to
  // the squashed path anyway.
  assign hazard    = rs1_hazard | rs2_hazard;
  assign valid_out = full & ~hazard & ~flush;
  assign issue     = valid_out & ready_out;
  assign ready_in  = ~full | issue | flush;
  assign accept    = valid_in & ready_in & ~flush;

  // Occupancy: flush wins over everything, a new accept refills the slot
  // even when the old entry issues in the same cycle (back-to-back issue),
  // otherwise an issue empties the slot.
  always_comb begin
    full_next = full;
    if (flush) begin
      full_next = 1'b0;
    end else if (valid_in && ready_in) begin
      full_next = 1'b1;
    end else if (issue) begin
      full_next = 1'b0;
    end
  end

  // Occupancy register; reset drops any held instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else begin
      full <= full_next;
    end
  end

  // Payload register; only written on a real accept so it holds steady
  // across stalls and is not overwritten by an instruction seen during a
  // flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_pc              <= '0;
      p_branch_predict  <= 1'b0;
      p_rs1_ren         <= 1'b0;
      p_rs2_ren         <= 1'b0;
      p_rd_wen          <= 1'b0;
      p_rs1_idx         <= '0;
      p_rs2_idx         <= '0;
      p_rd_idx          <= '0;
      p_imm             <= '0;
      p_bj_dec_inst_bus <= '0;
      p_alu_inst_bus    <= '0;
      p_lsu_inst_bus    <= '0;
    end else if (accept) begin
      p_pc              <= i_pc;
      p_branch_predict  <= i_branch_predict;
      p_rs1_ren         <= i_rs1_ren;
      p_rs2_ren         <= i_rs2_ren;
      p_rd_wen          <= i_rd_wen;
      p_rs1_idx         <= i_rs1_idx;
      p_rs2_idx         <= i_rs2_idx;
      p_rd_idx          <= i_rd_idx;
      p_imm             <= i_imm;
      p_bj_dec_inst_bus <= i_bj_dec_inst_bus;
      p_alu_inst_bus    <= i_alu_inst_bus;
      p_lsu_inst_bus    <= i_lsu_inst_bus;
    end
  end

  assign o_pc              = p_pc;
  assign o_branch_predict  = p_branch_predict;
  assign o_rs1_ren         = p_rs1_ren;
  assign o_rs2_ren         = p_rs2_ren;
  assign o_rd_wen          = p_rd_wen;
  assign o_rs1_idx         = p_rs1_idx;
  assign o_rs2_idx         = p_rs2_idx;
  assign o_rd_idx          = p_rd_idx;
  assign o_imm             = p_imm;
  assign o_bj_dec_inst_bus = p_bj_dec_inst_bus;
  assign o_alu_inst_bus    = p_alu_inst_bus;
  assign o_lsu_inst_bus    = p_lsu_inst_bus;

`ifdef CORE_ID_PERF_CNT_EN
  // Stall cycles count only genuine operand waits; a flush cycle is not a
  // stall even if the dying instruction had a hazard. Both counters wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (full && hazard && !flush) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
      if (issue) begin
        perf_issue_cnt <= perf_issue_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_id_issue.sv
// tb_core_id_issue
// Self-checking bench for core_id_issue: directed scenarios followed by a
// randomized run, all checked each cycle against a behavioural model of the
// issue slot (one optional held instruction plus operand resolution rules).
module tb_core_id_issue;
  import core_id_issue_pkg::*;

  typedef struct packed {
    logic [CORE_PC_SIZE-1:0]           pc;
    logic                              bp;
    logic                              rs1_ren;
    logic                              rs2_ren;
    logic                              rd_wen;
    logic [CORE_RFIDX_WIDTH-1:0]       rs1_idx;
    logic [CORE_RFIDX_WIDTH-1:0]       rs2_idx;
    logic [CORE_RFIDX_WIDTH-1:0]       rd_idx;
    logic [CORE_IMM_WIDTH-1:0]         imm;
    logic [CORE_DECINFO_BJ_WIDTH-1:0]  bj;
    logic [CORE_DECINFO_ALU_WIDTH-1:0] alu;
    logic [CORE_DECINFO_LSU_WIDTH-1:0] lsu;
  } inst_t;

  logic                              clk;
  logic                              rst_n;
  logic                              valid_in;
  logic                              ready_in;
  logic [CORE_PC_SIZE-1:0]           i_pc;
  logic                              i_branch_predict;
  logic                              i_rs1_ren;
  logic                              i_rs2_ren;
  logic                              i_rd_wen;
  logic [CORE_RFIDX_WIDTH-1:0]       i_rs1_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       i_rs2_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       i_rd_idx;
  logic [CORE_IMM_WIDTH-1:0]         i_imm;
  logic [CORE_DECINFO_BJ_WIDTH-1:0]  i_bj_dec_inst_bus;
  logic [CORE_DECINFO_ALU_WIDTH-1:0] i_alu_inst_bus;
  logic [CORE_DECINFO_LSU_WIDTH-1:0] i_lsu_inst_bus;
  logic [CORE_RFIDX_WIDTH-1:0]       rf_rs1_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       rf_rs2_idx;
  logic [CORE_XLEN-1:0]              rf_rs1_dat;
  logic [CORE_XLEN-1:0]              rf_rs2_dat;
  logic [CORE_RFIDX_WIDTH-1:0]       rd_idx_ex_forward;
  logic                              rd_wen_ex_forward;
  logic [CORE_XLEN-1:0]              rd_dat_ex_forward;
  logic                              exu_busy;
  logic                              wb_en;
  logic [CORE_RFIDX_WIDTH-1:0]       wb_idx;
  logic [CORE_XLEN-1:0]              wb_data;
  logic                              cmt_pipeline_flush_req;
  logic                              valid_out;
  logic                              ready_out;
  logic [CORE_PC_SIZE-1:0]           o_pc;
  logic                              o_branch_predict;
  logic                              o_rs1_ren;
  logic                              o_rs2_ren;
  logic                              o_rd_wen;
  logic [CORE_RFIDX_WIDTH-1:0]       o_rs1_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       o_rs2_idx;
  logic [CORE_RFIDX_WIDTH-1:0]       o_rd_idx;
  logic [CORE_IMM_WIDTH-1:0]         o_imm;
  logic [CORE_DECINFO_BJ_WIDTH-1:0]  o_bj_dec_inst_bus;
  logic [CORE_DECINFO_ALU_WIDTH-1:0] o_alu_inst_bus;
  logic [CORE_DECINFO_LSU_WIDTH-1:0] o_lsu_inst_bus;
  logic [CORE_XLEN-1:0]              o_rs1_dat;
  logic [CORE_XLEN-1:0]              o_rs2_dat;
`ifdef CORE_ID_PERF_CNT_EN
  logic [31:0]                       perf_stall_cnt;
  logic [31:0]                       perf_issue_cnt;
  logic [31:0]                       m_stall, m_stall_nx, stall_base;
  logic [31:0]                       m_issue, m_issue_nx, issue_base;
`endif

  // Register file model; read data follows the DUT's read address.
  logic [CORE_XLEN-1:0] regfile [32];
  assign rf_rs1_dat = regfile[rf_rs1_idx];
  assign rf_rs2_dat = regfile[rf_rs2_idx];

  // Reference model state.
  logic  m_full, m_full_nx;
  inst_t m_inst, m_inst_nx;

  int n_assert;
  int n_fail;

  core_id_issue dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .valid_in               (valid_in),
    .ready_in               (ready_in),
    .i_pc                   (i_pc),
    .i_branch_predict       (i_branch_predict),
    .i_rs1_ren              (i_rs1_ren),
    .i_rs2_ren              (i_rs2_ren),
    .i_rd_wen               (i_rd_wen),
    .i_rs1_idx              (i_rs1_idx),
    .i_rs2_idx              (i_rs2_idx),
    .i_rd_idx               (i_rd_idx),
    .i_imm                  (i_imm),
    .i_bj_dec_inst_bus      (i_bj_dec_inst_bus),
    .i_alu_inst_bus         (i_alu_inst_bus),
    .i_lsu_inst_bus         (i_lsu_inst_bus),
    .rf_rs1_idx             (rf_rs1_idx),
    .rf_rs2_idx             (rf_rs2_idx),
    .rf_rs1_dat             (rf_rs1_dat),
    .rf_rs2_dat             (rf_rs2_dat),
    .rd_idx_ex_forward      (rd_idx_ex_forward),
    .rd_wen_ex_forward      (rd_wen_ex_forward),
    .rd_dat_ex_forward      (rd_dat_ex_forward),
    .exu_busy               (exu_busy),
    .wb_en                  (wb_en),
    .wb_idx                 (wb_idx),
    .wb_data                (wb_data),
    .cmt_pipeline_flush_req (cmt_pipeline_flush_req),
    .valid_out              (valid_out),
    .ready_out              (ready_out),
    .o_pc                   (o_pc),
    .o_branch_predict       (o_branch_predict),
    .o_rs1_ren              (o_rs1_ren),
    .o_rs2_ren              (o_rs2_ren),
    .o_rd_wen               (o_rd_wen),
    .o_rs1_idx              (o_rs1_idx),
    .o_rs2_idx              (o_rs2_idx),
    .o_rd_idx               (o_rd_idx),
    .o_imm                  (o_imm),
    .o_bj_dec_inst_bus      (o_bj_dec_inst_bus),
    .o_alu_inst_bus         (o_alu_inst_bus),
    .o_lsu_inst_bus         (o_lsu_inst_bus),
`ifdef CORE_ID_PERF_CNT_EN
    .perf_stall_cnt         (perf_stall_cnt),
    .perf_issue_cnt         (perf_issue_cnt),
`endif
    .o_rs1_dat              (o_rs1_dat),
    .o_rs2_dat              (o_rs2_dat)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Operand as the architecture defines it for the held instruction and
  // the forwarding sources visible this cycle.
  function automatic logic [CORE_XLEN-1:0] refOperand(input logic ren,
                                                      input logic [CORE_RFIDX_WIDTH-1:0] idx,
                                                      output logic hz);
    hz = 1'b0;
    if (!m_full || !ren || idx == 0) return '0;
    if (rd_wen_ex_forward && rd_idx_ex_forward == idx) begin
      hz = exu_busy;
      return rd_dat_ex_forward;
    end
    if (wb_en && wb_idx == idx) return wb_data;
    return regfile[idx];
  endfunction

  task automatic presentInst(input logic [31:0] pc, input logic r1en, input int r1,
                             input logic r2en, input int r2, input int rd);
    valid_in          = 1'b1;
    i_pc              = pc;
    i_branch_predict  = pc[2];
    i_rs1_ren         = r1en;
    i_rs2_ren         = r2en;
    i_rd_wen          = 1'b1;
    i_rs1_idx         = 5'(r1);
    i_rs2_idx         = 5'(r2);
    i_rd_idx          = 5'(rd);
    i_imm             = pc ^ 32'h5A5A_0000;
    i_bj_dec_inst_bus = pc[11:2];
    i_alu_inst_bus    = pc[17:2];
    i_lsu_inst_bus    = pc[13:2];
  endtask

  // Waits for the falling edge, then either quiets every input (directed
  // steps set what they need afterwards) or randomizes them.
  task automatic applyStimulus(input bit rand_en);
    logic [31:0] r;
    @(negedge clk);
    valid_in               = 1'b0;
    i_pc                   = '0;
    i_branch_predict       = 1'b0;
    i_rs1_ren              = 1'b0;
    i_rs2_ren              = 1'b0;
    i_rd_wen               = 1'b0;
    i_rs1_idx              = '0;
    i_rs2_idx              = '0;
    i_rd_idx               = '0;
    i_imm                  = '0;
    i_bj_dec_inst_bus      = '0;
    i_alu_inst_bus         = '0;
    i_lsu_inst_bus         = '0;
    rd_idx_ex_forward      = '0;
    rd_wen_ex_forward      = 1'b0;
    rd_dat_ex_forward      = '0;
    exu_busy               = 1'b0;
    wb_en                  = 1'b0;
    wb_idx                 = '0;
    wb_data                = '0;
    cmt_pipeline_flush_req = 1'b0;
    ready_out              = 1'b1;
    if (rand_en) begin
      r = $urandom;
      valid_in          = ($urandom_range(0, 9) < 7);
      i_pc              = $urandom;
      i_branch_predict  = r[0];
      i_rs1_ren         = r[1] | r[2];
      i_rs2_ren         = r[3] | r[4];
      i_rd_wen          = r[5];
      i_rs1_idx         = 5'($urandom_range(0, 7));
      i_rs2_idx         = 5'($urandom_range(0, 7));
      i_rd_idx          = 5'($urandom_range(0, 31));
      i_imm             = $urandom;
      i_bj_dec_inst_bus = r[15:6];
      i_alu_inst_bus    = r[31:16];
      i_lsu_inst_bus    = r[27:16];
      rd_wen_ex_forward = ($urandom_range(0, 1) == 1);
      rd_idx_ex_forward = 5'($urandom_range(0, 7));
      rd_dat_ex_forward = $urandom;
      exu_busy          = ($urandom_range(0, 3) == 0);
      wb_en             = ($urandom_range(0, 1) == 1);
      wb_idx            = 5'($urandom_range(0, 7));
      wb_data           = $urandom;
      cmt_pipeline_flush_req = ($urandom_range(0, 11) == 0);
      ready_out         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) regfile[$urandom_range(0, 31)] = $urandom;
    end
  endtask

  // Compares every output against the model and prepares the model's
  // next state from the inputs applied this cycle.
  task automatic checkOutput();
    logic hz1, hz2, exp_valid, exp_ready;
    logic [CORE_XLEN-1:0] e1, e2;
    inst_t cur;
    #1;
    e1 = refOperand(m_inst.rs1_ren, m_inst.rs1_idx, hz1);
    e2 = refOperand(m_inst.rs2_ren, m_inst.rs2_idx, hz2);
    exp_valid = m_full && !(hz1 || hz2) && !cmt_pipeline_flush_req;
    exp_ready = !m_full || (exp_valid && ready_out) || cmt_pipeline_flush_req;
    checkEq("valid_out", valid_out, exp_valid);
    checkEq("ready_in", ready_in, exp_ready);
    checkEq("rf_rs1_idx", rf_rs1_idx, m_inst.rs1_idx);
    checkEq("rf_rs2_idx", rf_rs2_idx, m_inst.rs2_idx);
    checkEq("o_rs1_dat", o_rs1_dat, e1);
    checkEq("o_rs2_dat", o_rs2_dat, e2);
    cur = '{o_pc, o_branch_predict, o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx,
            o_rs2_idx, o_rd_idx, o_imm, o_bj_dec_inst_bus, o_alu_inst_bus, o_lsu_inst_bus};
    checkEq("payload_lo", cur[63:0], m_inst[63:0]);
    checkEq("payload_hi", 64'(cur >> 64), 64'(m_inst >> 64));
`ifdef CORE_ID_PERF_CNT_EN
    checkEq("perf_stall_cnt", perf_stall_cnt, m_stall);
    checkEq("perf_issue_cnt", perf_issue_cnt, m_issue);
    m_stall_nx = m_stall + ((m_full && (hz1 || hz2) && !cmt_pipeline_flush_req) ? 1 : 0);
    m_issue_nx = m_issue + ((exp_valid && ready_out) ? 1 : 0);
`endif
    m_inst_nx = m_inst;
    m_full_nx = m_full;
    if (cmt_pipeline_flush_req) begin
      m_full_nx = 1'b0;
    end else if (valid_in && exp_ready) begin
      m_full_nx = 1'b1;
      m_inst_nx = '{i_pc, i_branch_predict, i_rs1_ren, i_rs2_ren, i_rd_wen, i_rs1_idx,
                    i_rs2_idx, i_rd_idx, i_imm, i_bj_dec_inst_bus, i_alu_inst_bus, i_lsu_inst_bus};
    end else if (exp_valid && ready_out) begin
      m_full_nx = 1'b0;
    end
  endtask

  task automatic advanceClock();
    @(posedge clk);
    m_full = m_full_nx;
    m_inst = m_inst_nx;
`ifdef CORE_ID_PERF_CNT_EN
    m_stall = m_stall_nx;
    m_issue = m_issue_nx;
`endif
  endtask

  task automatic resetModel();
    m_full = 1'b0;
    m_inst = '0;
`ifdef CORE_ID_PERF_CNT_EN
    m_stall = '0;
    m_issue = '0;
`endif
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int k = 0; k < 32; k++) regfile[k] = $urandom;
    resetModel();
    rst_n = 1'b0;
    applyStimulus(0);
    applyStimulus(0);
    rst_n = 1'b1;

    // Reset state.
    checkOutput();
    checkEq("rst_valid_out", valid_out, 1'b0);
    checkEq("rst_ready_in", ready_in, 1'b1);
    checkEq("rst_o_pc", o_pc, 0);
    checkEq("rst_o_rs1_dat", o_rs1_dat, 0);
    advanceClock();

    // addi x1, x0: one cycle from accept to valid_out, x0 reads as zero.
    $display("[TB] basic issue");
    applyStimulus(0);
    presentInst(32'h100, 1'b1, 0, 1'b0, 0, 1);
    checkOutput();
    checkEq("accept_valid_out", valid_out, 1'b0);
    advanceClock();
    applyStimulus(0);
    checkOutput();
    checkEq("addi_valid_out", valid_out, 1'b1);
    checkEq("addi_rs1_dat", o_rs1_dat, 0);
    checkEq("addi_pc", o_pc, 32'h100);
    advanceClock();

    // EX forwarding without stall.
    $display("[TB] EX forward");
    applyStimulus(0);
    presentInst(32'h104, 1'b1, 5, 1'b0, 0, 2);
    checkOutput();
    advanceClock();
    applyStimulus(0);
    rd_wen_ex_forward = 1'b1; rd_idx_ex_forward = 5'd5; rd_dat_ex_forward = 32'h1234;
    checkOutput();
    checkEq("exfwd_rs1_dat", o_rs1_dat, 32'h1234);
    checkEq("exfwd_valid_out", valid_out, 1'b1);
    advanceClock();

    // Load-use stall for three cycles, issue on the fourth.
    $display("[TB] load-use stall");
    applyStimulus(0);
    presentInst(32'h108, 1'b1, 5, 1'b0, 0, 3);
    checkOutput();
    advanceClock();
`ifdef CORE_ID_PERF_CNT_EN
    stall_base = m_stall;
`endif
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0);
      rd_wen_ex_forward = 1'b1; rd_idx_ex_forward = 5'd5; rd_dat_ex_forward = 32'h55;
      exu_busy = 1'b1;
      checkOutput();
      checkEq("stall_valid_out", valid_out, 1'b0);
      checkEq("stall_ready_in", ready_in, 1'b0);
      advanceClock();
    end
    applyStimulus(0);
    rd_wen_ex_forward = 1'b1; rd_idx_ex_forward = 5'd5; rd_dat_ex_forward = 32'h77;
    checkOutput();
    checkEq("unstall_valid_out", valid_out, 1'b1);
    checkEq("unstall_rs1_dat", o_rs1_dat, 32'h77);
`ifdef CORE_ID_PERF_CNT_EN
    checkEq("stall_count", perf_stall_cnt, stall_base + 3);
`endif
    advanceClock();

    // EX has priority over WB for the same register.
    $display("[TB] EX over WB priority");
    applyStimulus(0);
    presentInst(32'h10C, 1'b0, 0, 1'b1, 7, 4);
    checkOutput();
    advanceClock();
    applyStimulus(0);
    wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'hAA;
    rd_wen_ex_forward = 1'b1; rd_idx_ex_forward = 5'd7; rd_dat_ex_forward = 32'hBB;
    checkOutput();
    checkEq("prio_rs2_dat", o_rs2_dat, 32'hBB);
    advanceClock();

    // Flush with a held instruction and a new one presented.
    $display("[TB] flush");
    applyStimulus(0);
    presentInst(32'h110, 1'b0, 0, 1'b0, 0, 5);
    checkOutput();
    advanceClock();
    applyStimulus(0);
    presentInst(32'h114, 1'b0, 0, 1'b0, 0, 6);
    cmt_pipeline_flush_req = 1'b1;
    checkOutput();
    checkEq("flush_valid_out", valid_out, 1'b0);
    checkEq("flush_ready_in", ready_in, 1'b1);
    advanceClock();
    applyStimulus(0);
    checkOutput();
    checkEq("postflush_valid_out", valid_out, 1'b0);
    advanceClock();

    // Backpressure then four back-to-back issues.
    $display("[TB] backpressure and back-to-back");
    applyStimulus(0);
    presentInst(32'h200, 1'b0, 0, 1'b0, 0, 8);
    checkOutput();
    advanceClock();
`ifdef CORE_ID_PERF_CNT_EN
    issue_base = m_issue;
`endif
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0);
      ready_out = 1'b0;
      presentInst(32'h204, 1'b0, 0, 1'b0, 0, 9);
      checkOutput();
      checkEq("bp_ready_in", ready_in, 1'b0);
      checkEq("bp_pc_hold", o_pc, 32'h200);
      advanceClock();
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0);
      if (c < 3) presentInst(32'h204 + 32'(4 * c), 1'b0, 0, 1'b0, 0, 10);
      checkOutput();
      checkEq("b2b_valid_out", valid_out, 1'b1);
      checkEq("b2b_pc", o_pc, (c == 0) ? 32'h200 : 32'h204 + 32'(4 * (c - 1)));
      advanceClock();
    end
`ifdef CORE_ID_PERF_CNT_EN
    applyStimulus(0);
    checkOutput();
    checkEq("issue_count", perf_issue_cnt, issue_base + 4);
    advanceClock();
`endif

    // Randomized traffic with an asynchronous reset in the middle.
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1);
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1;
        checkEq("async_rst_valid_out", valid_out, 1'b0);
        checkEq("async_rst_ready_in", ready_in, 1'b1);
        checkEq("async_rst_pc", o_pc, 0);
        resetModel();
        @(posedge clk);
        applyStimulus(1);
        rst_n = 1'b1;
      end
      checkOutput();
      advanceClock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
